// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
//  eth_pkg : shared widths, beat structures and packer state encoding
//  Revision: 1.0
// ============================================================================
package eth_pkg;

    localparam int ETH_NARROW_W = 74;
    localparam int ETH_WIDE_W   = 2 * ETH_NARROW_W;

    typedef struct packed {
        logic [ETH_NARROW_W-1:0] data;
        logic                    sop;
        logic                    eop;
    } narrow_beat_t;

    typedef struct packed {
        logic [ETH_WIDE_W-1:0] data;
        logic                  sop;
        logic                  eop;
        logic                  empty;
    } wide_beat_t;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_HALF  = 1'b1
    } pack_state_t;

endpackage
`default_nettype wire

// File: rtl/eth_doublewidth_packer_if.sv
`default_nettype none
// ============================================================================
//  eth_doublewidth_packer_if : narrow-in / wide-out Avalon-ST bundle
//  Revision: 1.0
// ============================================================================
interface eth_doublewidth_packer_if
    import eth_pkg::*;
#(
    parameter int IN_W = ETH_NARROW_W
);
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic              in_startofpacket;
    logic              in_endofpacket;
    logic              out_valid;
    logic              out_ready;
    logic [2*IN_W-1:0] out_data;
    logic              out_startofpacket;
    logic              out_endofpacket;
    logic              out_empty;

    // The adapter itself is the slave view; the upstream/downstream pair is the master view.
    modport slave (
        input  in_valid, in_data, in_startofpacket, in_endofpacket, out_ready,
        output in_ready, out_valid, out_data, out_startofpacket, out_endofpacket, out_empty
    );

    modport master (
        output in_valid, in_data, in_startofpacket, in_endofpacket, out_ready,
        input  in_ready, out_valid, out_data, out_startofpacket, out_endofpacket, out_empty
    );
endinterface
`default_nettype wire

// File: rtl/eth_doublewidth_packer.sv
`default_nettype none
// ============================================================================
//  eth_doublewidth_packer : packs two narrow beats of a packet into one wide
//  beat. Optional ETH_DW_STATS_EN adds pkt_count / drop_count outputs.
//  Revision: 1.0
// ============================================================================
module eth_doublewidth_packer
    import eth_pkg::*;
#(
    parameter int IN_W = ETH_NARROW_W
)(
    input  logic                     clk,
    input  logic                     reset_n,
    eth_doublewidth_packer_if.slave  bus
`ifdef ETH_DW_STATS_EN
    ,
    output logic [31:0]              pkt_count,
    output logic [15:0]              drop_count
`endif
);

    narrow_beat_t    in_beat;
    pack_state_t     state_q, state_d;
    logic [IN_W-1:0] hold_data_q, hold_data_d;
    logic            hold_sop_q, hold_sop_d;
    wide_beat_t      out_q, out_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready;
    logic            in_accept;
    logic            out_accept;

    assign in_beat = '{data: bus.in_data, sop: bus.in_startofpacket, eop: bus.in_endofpacket};

    // Forced high in reset so upstream never sees a stale stall from the old output beat.
    assign in_ready   = !reset_n || !out_valid_q || bus.out_ready;
    assign in_accept  = bus.in_valid && in_ready;
    assign out_accept = out_valid_q && bus.out_ready;

    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        hold_sop_d  = hold_sop_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;

        if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (in_accept) begin
            if (state_q == ST_HALF && !in_beat.sop) begin
                out_d       = '{data: {hold_data_q, in_beat.data}, sop: hold_sop_q,
                                eop: in_beat.eop, empty: 1'b0};
                out_valid_d = 1'b1;
                state_d     = ST_EMPTY;
            end else if (in_beat.eop) begin
                // A new sop while half-full abandons the held beat and restarts here.
                out_d       = '{data: {in_beat.data, {IN_W{1'b0}}}, sop: in_beat.sop,
                                eop: 1'b1, empty: 1'b1};
                out_valid_d = 1'b1;
                state_d     = ST_EMPTY;
            end else begin
                hold_data_d = in_beat.data;
                hold_sop_d  = in_beat.sop;
                state_d     = ST_HALF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_EMPTY;
            hold_data_q <= '0;
            hold_sop_q  <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_sop_q  <= hold_sop_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready          = in_ready;
    assign bus.out_valid         = out_valid_q;
    assign bus.out_data          = out_q.data;
    assign bus.out_startofpacket = out_q.sop;
    assign bus.out_endofpacket   = out_q.eop;
    assign bus.out_empty         = out_q.empty;

`ifdef ETH_DW_STATS_EN
    logic [31:0] pkt_count_q, pkt_count_d;
    logic [15:0] drop_count_q, drop_count_d;
    logic        drop_event;

    assign drop_event = in_accept && (state_q == ST_HALF) && in_beat.sop;

    always_comb begin
        pkt_count_d  = pkt_count_q;
        drop_count_d = drop_count_q;
        if (out_accept && out_q.eop) begin
            pkt_count_d = pkt_count_q + 32'd1;
        end
        if (drop_event && drop_count_q != 16'hFFFF) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pkt_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            pkt_count_q  <= pkt_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign pkt_count  = pkt_count_q;
    assign drop_count = drop_count_q;
`else
    logic unused_out_accept;
    assign unused_out_accept = out_accept;
`endif

endmodule
`default_nettype wire

// File: tb/tb_eth_doublewidth_packer.sv
`default_nettype none
// ============================================================================
//  tb_eth_doublewidth_packer : directed self-checking bench for the packer
//  Revision: 1.0
// ============================================================================
module tb_eth_doublewidth_packer;

    localparam int W = 74;

    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;

`ifdef ETH_DW_STATS_EN
    logic [31:0] pkt_count;
    logic [15:0] drop_count;
`endif

    eth_doublewidth_packer_if #(.IN_W(W)) bus ();

    eth_doublewidth_packer #(.IN_W(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus)
`ifdef ETH_DW_STATS_EN
        ,
        .pkt_count  (pkt_count),
        .drop_count (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] bv(input logic [7:0] tag, input int idx);
        return {tag, 2'b10, 32'hC0DE_0000 + 32'(idx), 32'(idx) * 32'h0101_0101};
    endfunction

    task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [2*W-1:0] d,
                           input logic s, input logic e, input logic em);
        chk({tag, "_valid"}, bus.out_valid, v);
        chk({tag, "_data"},  bus.out_data, d);
        chk({tag, "_sop"},   bus.out_startofpacket, s);
        chk({tag, "_eop"},   bus.out_endofpacket, e);
        chk({tag, "_empty"}, bus.out_empty, em);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] d, input logic s, input logic e);
        bus.in_valid         = 1'b1;
        bus.in_data          = d;
        bus.in_startofpacket = s;
        bus.in_endofpacket   = e;
    endtask

    // One accepted narrow beat: in_ready must be high, then the edge consumes it.
    task automatic send(input string tag, input logic [W-1:0] d, input logic s, input logic e);
        drive(d, s, e);
        #1;
        chk({tag, "_in_ready"}, bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    initial begin
        int sent;
        int got;
        int stalls;
        logic [2*W-1:0] exp_w;

        vectors              = 0;
        miscompares          = 0;
        reset_n              = 1'b0;
        bus.in_valid         = 1'b0;
        bus.in_data          = '0;
        bus.in_startofpacket = 1'b0;
        bus.in_endofpacket   = 1'b0;
        bus.out_ready        = 1'b0;
        tick();
        tick();
        chk_out("rst", 1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        reset_n       = 1'b1;
        bus.out_ready = 1'b1;

        // 4-beat packet
        send("a0", bv(8'hA0, 0), 1'b1, 1'b0);
        chk("a0_nvalid", bus.out_valid, 1'b0);
        send("a1", bv(8'hA0, 1), 1'b0, 1'b0);
        chk_out("a01", 1'b1, {bv(8'hA0, 0), bv(8'hA0, 1)}, 1'b1, 1'b0, 1'b0);
        send("a2", bv(8'hA0, 2), 1'b0, 1'b0);
        chk("a2_nvalid", bus.out_valid, 1'b0);
        send("a3", bv(8'hA0, 3), 1'b0, 1'b1);
        chk_out("a23", 1'b1, {bv(8'hA0, 2), bv(8'hA0, 3)}, 1'b0, 1'b1, 1'b0);

        // 3-beat packet, odd tail
        send("b0", bv(8'hB0, 0), 1'b1, 1'b0);
        chk("b0_nvalid", bus.out_valid, 1'b0);
        send("b1", bv(8'hB0, 1), 1'b0, 1'b0);
        chk_out("b01", 1'b1, {bv(8'hB0, 0), bv(8'hB0, 1)}, 1'b1, 1'b0, 1'b0);
        send("b2", bv(8'hB0, 2), 1'b0, 1'b1);
        chk_out("b2", 1'b1, {bv(8'hB0, 2), {W{1'b0}}}, 1'b0, 1'b1, 1'b1);

        // 1-beat packet
        send("c0", bv(8'hC0, 0), 1'b1, 1'b1);
        chk_out("c0", 1'b1, {bv(8'hC0, 0), {W{1'b0}}}, 1'b1, 1'b1, 1'b1);

        // Missing eop: D0 is dropped
        send("d0", bv(8'hD0, 0), 1'b1, 1'b0);
        chk("d0_nvalid", bus.out_valid, 1'b0);
        send("e0", bv(8'hE0, 0), 1'b1, 1'b0);
        chk("e0_nvalid", bus.out_valid, 1'b0);
        send("e1", bv(8'hE0, 1), 1'b0, 1'b1);
        chk_out("e01", 1'b1, {bv(8'hE0, 0), bv(8'hE0, 1)}, 1'b1, 1'b1, 1'b0);
        tick();
        chk("e_idle_nvalid", bus.out_valid, 1'b0);
`ifdef ETH_DW_STATS_EN
        chk("stat_pkt_4", pkt_count, 32'd4);
        chk("stat_drop_1", drop_count, 16'd1);
`endif

        // Short stall with a competing input beat that must not be taken
        bus.out_ready = 1'b0;
        send("h0", bv(8'h11, 0), 1'b1, 1'b0);
        send("h1", bv(8'h11, 1), 1'b0, 1'b1);
        drive(bv(8'hEE, 0), 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk("h_stall_in_ready", bus.in_ready, 1'b0);
            chk_out("h_stall", 1'b1, {bv(8'h11, 0), bv(8'h11, 1)}, 1'b1, 1'b1, 1'b0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("h_drained", bus.out_valid, 1'b0);

        // 90-beat packet with a 5-cycle backpressure window
        sent   = 0;
        got    = 0;
        stalls = 0;
        for (int c = 0; c < 400 && got < 45; c++) begin
            bus.out_ready = !(c >= 20 && c < 25);
            if (sent < 90) drive(bv(8'h5A, sent), sent == 0, sent == 89);
            else           bus.in_valid = 1'b0;
            #1;
            exp_w = {bv(8'h5A, 2 * got), bv(8'h5A, 2 * got + 1)};
            if (bus.out_valid && !bus.out_ready) begin
                stalls++;
                chk("bp_in_ready", bus.in_ready, 1'b0);
                chk("bp_hold", bus.out_data, exp_w);
            end
            if (bus.out_valid && bus.out_ready) begin
                chk_out("bp", 1'b1, exp_w, got == 0, got == 44, 1'b0);
                got++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("bp_wide_count", 32'(got), 32'd45);
        chk("bp_narrow_count", 32'(sent), 32'd90);
        chk("bp_stall_seen", stalls >= 4, 1'b1);
        tick();
        chk("bp_drained", bus.out_valid, 1'b0);

        // Reset with a stalled output beat pending
        bus.out_ready = 1'b0;
        send("p0", bv(8'h77, 0), 1'b1, 1'b1);
        chk("p0_valid", bus.out_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("p_rst_in_ready", bus.in_ready, 1'b1);
        tick();
        chk_out("p_rst", 1'b0, '0, 1'b0, 1'b0, 1'b0);
        reset_n       = 1'b1;
        bus.out_ready = 1'b1;

        // Reset after the first beat of a packet, then a clean 2-beat packet
        send("g0", bv(8'h99, 0), 1'b1, 1'b0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("g_rst_nvalid", bus.out_valid, 1'b0);
        send("f0", bv(8'hF0, 0), 1'b1, 1'b0);
        chk("f0_nvalid", bus.out_valid, 1'b0);
        send("f1", bv(8'hF0, 1), 1'b0, 1'b1);
        chk_out("f01", 1'b1, {bv(8'hF0, 0), bv(8'hF0, 1)}, 1'b1, 1'b1, 1'b0);
        tick();
        chk("f_idle_nvalid", bus.out_valid, 1'b0);
`ifdef ETH_DW_STATS_EN
        chk("stat_pkt_after_rst", pkt_count, 32'd1);
        chk("stat_drop_after_rst", drop_count, 16'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
